// File: rtl/data_bus_bridge_pkg.sv
// Shared types and constants for the data bus bridge: state encoding,
// bus widths and the default error/timeout values.
package data_bus_bridge_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int BE_W    = 4;
   localparam int TIMER_W = 32;

   localparam int unsigned       DEFAULT_TIMEOUT  = 16;
   localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RDONE = 2'd3
   } bridge_state_e;

endpackage

// File: rtl/data_bus_bridge_if.sv
// Core-side and slave-side bus signals of the bridge; master is the bridge's
// own view, slave is the view of whoever drives the core and the slave.
interface data_bus_bridge_if;
   import data_bus_bridge_pkg::*;

   logic              iReadEnable;
   logic              iWriteEnable;
   logic [BE_W-1:0]   iByteEnable;
   logic [ADDR_W-1:0] iAddress;
   logic [DATA_W-1:0] iWriteData;
   logic [DATA_W-1:0] oReadData;
   logic              oStall;
   logic              oBusError;
   logic              oReq;
   logic              oWe;
   logic [BE_W-1:0]   oBe;
   logic [ADDR_W-1:0] oAddr;
   logic [DATA_W-1:0] oWData;
   logic              iAck;
   logic [DATA_W-1:0] iRData;

   modport master (
      input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, iAck, iRData,
      output oReadData, oStall, oBusError, oReq, oWe, oBe, oAddr, oWData
   );

   modport slave (
      output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, iAck, iRData,
      input  oReadData, oStall, oBusError, oReq, oWe, oBe, oAddr, oWData
   );

endinterface

// File: rtl/data_bus_bridge_timeout.sv
// Counts request cycles without an ack; expired flags the cycle in which the
// count would reach limit. A limit of zero never expires.
module bus_timeout_counter
   import data_bus_bridge_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               clear,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (limit != '0) && (count_q == limit - TIMER_W'(1));

endmodule

// File: rtl/data_bus_bridge.sv
// Turns the core's fixed-timing data bus into a req/ack handshake with a
// one-entry posted write buffer, stall generation and timeout abort.
module data_bus_bridge
   import data_bus_bridge_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
)(
   input logic               iCLK,
   input logic               iRST,
   data_bus_bridge_if.master bus
);

   bridge_state_e     state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic              stall;
   logic              expired;

   bus_timeout_counter u_timeout (
      .clk     (iCLK),
      .rst     (iRST),
      .enable  (req_q & ~bus.iAck),
      .clear   (~req_q | bus.iAck),
      .limit   (TIMER_W'(TIMEOUT_CYCLES)),
      .expired (expired)
   );

   // The slave-side address/BE/data registers double as the posted write buffer.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bus_err_d = 1'b0;
      stall     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.iWriteEnable) begin
               state_d = ST_WRITE;
               req_d   = 1'b1;
               we_d    = 1'b1;
               be_d    = bus.iByteEnable;
               addr_d  = bus.iAddress;
               wdata_d = bus.iWriteData;
            end else if (bus.iReadEnable) begin
               stall   = 1'b1;
               state_d = ST_READ;
               req_d   = 1'b1;
               we_d    = 1'b0;
               be_d    = bus.iByteEnable;
               addr_d  = bus.iAddress;
            end
         end
         ST_WRITE: begin
            stall = bus.iReadEnable | bus.iWriteEnable;
            if (bus.iAck) begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (expired) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_READ: begin
            stall = 1'b1;
            if (bus.iAck) begin
               rdata_d = bus.iRData;
               req_d   = 1'b0;
               state_d = ST_RDONE;
            end else if (expired) begin
               rdata_d   = ERR_DATA;
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ST_RDONE;
            end
         end
         ST_RDONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.oStall    = stall;
   assign bus.oReq      = req_q;
   assign bus.oWe       = we_q;
   assign bus.oBe       = be_q;
   assign bus.oAddr     = addr_q;
   assign bus.oWData    = wdata_q;
   assign bus.oReadData = rdata_q;
   assign bus.oBusError = bus_err_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge: directed handshake/timeout/reset
// steps followed by random traffic checked against a word-memory model.
module tb_data_bus_bridge;
   import data_bus_bridge_pkg::*;

   localparam int WAIT_LIMIT = 300;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } txn_t;

   logic iCLK;
   logic iRST;
   int   assert_count;
   int   fail_count;
   int   err_pulses;
   int   ack_after_w;
   int   ack_after_r;

   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];
   txn_t        exp_log[$];
   txn_t        act_log[$];

   data_bus_bridge_if bus ();
   data_bus_bridge_if bus0 ();

   data_bus_bridge #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   data_bus_bridge #(.TIMEOUT_CYCLES(0), .ERR_DATA(32'hDEADBEEF)) dut0 (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus0)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int l = 0; l < 4; l++) begin
         if (be[l]) r[8*l +: 8] = new_w[8*l +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] slave_word(input logic [31:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      assert_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic re, input logic we, input logic [3:0] be,
                                input logic [31:0] a, input logic [31:0] d);
      bus.iReadEnable  = re;
      bus.iWriteEnable = we;
      bus.iByteEnable  = be;
      bus.iAddress     = a;
      bus.iWriteData   = d;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      slave_mem[a] = d;
      model_mem[a] = d;
   endtask

   // Core-side write: holds the request until the bridge stops stalling.
   task automatic coreWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            output int stalls);
      stalls = 0;
      applyStimulus(1'b0, 1'b1, be, a, d);
      #1;
      while (bus.oStall === 1'b1 && stalls < WAIT_LIMIT) begin
         @(posedge iCLK); #1;
         stalls++;
      end
      if (stalls >= WAIT_LIMIT) checkOutput("write_accept_bound", 128'(bus.oStall), 128'(0));
      @(posedge iCLK);
      model_mem[a] = merge(model_word(a), d, be);
      exp_log.push_back('{we: 1'b1, addr: a, be: be, data: d});
      #1;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic coreRead(input logic [31:0] a, input logic [3:0] be, output logic [31:0] d,
                           output int stalls, output logic err);
      stalls = 0;
      exp_log.push_back('{we: 1'b0, addr: a, be: be, data: 32'h0});
      applyStimulus(1'b1, 1'b0, be, a, 32'h0);
      #1;
      while (bus.oStall === 1'b1 && stalls < WAIT_LIMIT) begin
         @(posedge iCLK); #1;
         stalls++;
      end
      if (stalls >= WAIT_LIMIT) checkOutput("read_done_bound", 128'(bus.oStall), 128'(0));
      d   = bus.oReadData;
      err = bus.oBusError;
      @(posedge iCLK); #1;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   // Slave model: acks after a programmable number of request cycles and
   // checks that the request fields hold steady while waiting.
   initial begin
      int k;
      int lim;
      logic [68:0] cap;
      k = 0;
      bus.iAck   = 1'b0;
      bus.iRData = 32'h0;
      forever begin
         @(negedge iCLK);
         bus.iAck = 1'b0;
         if (bus.oReq === 1'b1) begin
            if (k == 0) begin
               cap = {bus.oWe, bus.oBe, bus.oAddr, bus.oWData};
            end else begin
               checkOutput("req_fields_stable", 128'({bus.oWe, bus.oBe, bus.oAddr, bus.oWData}), 128'(cap));
            end
            lim = bus.oWe ? ack_after_w : ack_after_r;
            if (lim >= 0 && k >= lim) begin
               bus.iAck = 1'b1;
               if (bus.oWe) begin
                  slave_mem[bus.oAddr] = merge(slave_word(bus.oAddr), bus.oWData, bus.oBe);
                  act_log.push_back('{we: 1'b1, addr: bus.oAddr, be: bus.oBe, data: bus.oWData});
               end else begin
                  bus.iRData = slave_word(bus.oAddr);
                  act_log.push_back('{we: 1'b0, addr: bus.oAddr, be: bus.oBe, data: bus.iRData});
               end
            end
            k++;
         end else begin
            k = 0;
         end
      end
   end

   initial begin
      err_pulses = 0;
      forever begin
         @(negedge iCLK);
         if (bus.oBusError === 1'b1) err_pulses++;
      end
   end

   initial begin
      int          stalls;
      int          n;
      int          e0;
      int          err0;
      logic        err;
      logic        done;
      logic [31:0] rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] old_w;
      logic [3:0]  be;

      assert_count = 0;
      fail_count   = 0;
      ack_after_w  = 0;
      ack_after_r  = 0;
      iRST = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      bus0.iReadEnable  = 1'b0;
      bus0.iWriteEnable = 1'b0;
      bus0.iByteEnable  = 4'h0;
      bus0.iAddress     = 32'h0;
      bus0.iWriteData   = 32'h0;
      bus0.iAck         = 1'b0;
      bus0.iRData       = 32'h0;

      // Reset values on both bridges.
      @(posedge iCLK); #2;
      checkOutput("reset_outputs", 128'({bus.oReq, bus.oWe, bus.oBe, bus.oAddr, bus.oWData,
                  bus.oReadData, bus.oBusError, bus.oStall}), 128'(0));
      checkOutput("reset_outputs_t0", 128'({bus0.oReq, bus0.oWe, bus0.oBe, bus0.oAddr,
                  bus0.oWData, bus0.oReadData, bus0.oBusError}), 128'(0));
      iRST = 1'b0;
      @(posedge iCLK); #1;

      // Posted write, acked on the third request cycle.
      ack_after_w = 2;
      coreWrite(32'h1000, 4'hF, 32'hCAFEF00D, stalls);
      checkOutput("wr_posted_stalls", 128'(stalls), 128'(0));
      #1;
      checkOutput("wr_req_fields", 128'({bus.oReq, bus.oWe, bus.oBe, bus.oAddr, bus.oWData}),
                  128'({1'b1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D}));
      n = 0;
      while (bus.oReq === 1'b1 && n < 50) begin
         n++;
         @(posedge iCLK); #1;
      end
      checkOutput("wr_req_cycles", 128'(n), 128'(3));

      // Read acked in its first request cycle.
      ack_after_r = 0;
      preload(32'h2000, 32'h12345678);
      coreRead(32'h2000, 4'hF, rd, stalls, err);
      checkOutput("rd_fast_stalls", 128'(stalls), 128'(2));
      checkOutput("rd_fast_data", 128'(rd), 128'(32'h12345678));
      checkOutput("rd_fast_err", 128'(err), 128'(0));

      // Read right behind a slow write to the same word.
      ack_after_w = 3;
      ack_after_r = 0;
      coreWrite(32'h3000, 4'hF, 32'h5A5A0F0F, stalls);
      checkOutput("raw_write_stalls", 128'(stalls), 128'(0));
      coreRead(32'h3000, 4'hF, rd, stalls, err);
      checkOutput("raw_read_stalls", 128'(stalls), 128'(6));
      checkOutput("raw_read_data", 128'(rd), 128'(model_word(32'h3000)));
      checkOutput("raw_slave_order", 128'({act_log[act_log.size()-2].we, act_log[act_log.size()-1].we}),
                  128'(2'b10));

      // Read that is never acked: 16 request cycles, then error data.
      ack_after_r = -1;
      e0 = err_pulses;
      coreRead(32'h4000, 4'hF, rd, stalls, err);
      void'(exp_log.pop_back());
      checkOutput("timeout_stalls", 128'(stalls), 128'(17));
      checkOutput("timeout_data", 128'(rd), 128'(32'hDEADBEEF));
      checkOutput("timeout_err_in_rdone", 128'(err), 128'(1));
      checkOutput("timeout_err_pulses", 128'(err_pulses - e0), 128'(1));

      // Ack arriving in the cycle the counter would expire.
      ack_after_r = 15;
      preload(32'h4400, 32'h600DCAFE);
      e0 = err_pulses;
      coreRead(32'h4400, 4'hF, rd, stalls, err);
      checkOutput("edge_ack_stalls", 128'(stalls), 128'(17));
      checkOutput("edge_ack_data", 128'(rd), 128'(32'h600DCAFE));
      @(posedge iCLK); #1;
      checkOutput("edge_ack_no_err", 128'(err_pulses - e0), 128'(0));

      // Timeout disabled: a 100-cycle ack delay completes normally.
      bus0.iReadEnable = 1'b1;
      bus0.iAddress    = 32'h40;
      bus0.iByteEnable = 4'hF;
      n = 0; done = 1'b0; err0 = 0; rd = 32'h0;
      for (int c = 0; c < WAIT_LIMIT && !done; c++) begin
         #1;
         if (bus0.oBusError === 1'b1) err0++;
         if (bus0.oStall === 1'b0) begin
            done = 1'b1;
            rd   = bus0.oReadData;
         end else begin
            if (bus0.oReq === 1'b1) n++;
            bus0.iAck   = (n == 100);
            bus0.iRData = 32'h0BADF00D;
            @(posedge iCLK); #1;
         end
      end
      bus0.iReadEnable = 1'b0;
      bus0.iAck        = 1'b0;
      checkOutput("t0_done", 128'(done), 128'(1));
      checkOutput("t0_req_cycles", 128'(n), 128'(100));
      checkOutput("t0_data", 128'(rd), 128'(32'h0BADF00D));
      checkOutput("t0_no_err", 128'(err0), 128'(0));
      @(posedge iCLK); #1;

      // Reset while a posted write waits for its ack.
      ack_after_w = -1;
      old_w = model_word(32'h5000);
      coreWrite(32'h5000, 4'hF, 32'hFEEDFACE, stalls);
      void'(exp_log.pop_back());
      model_mem[32'h5000] = old_w;
      @(posedge iCLK); #1;
      checkOutput("rst_pre_req", 128'(bus.oReq), 128'(1));
      iRST = 1'b1;
      #1;
      checkOutput("rst_async_outputs", 128'({bus.oReq, bus.oWe, bus.oBe, bus.oAddr, bus.oWData,
                  bus.oReadData, bus.oBusError}), 128'(0));
      @(posedge iCLK); #1;
      iRST = 1'b0;
      ack_after_w = 0;
      ack_after_r = 1;
      preload(32'h6000, 32'h13579BDF);
      coreRead(32'h6000, 4'hF, rd, stalls, err);
      checkOutput("post_rst_stalls", 128'(stalls), 128'(3));
      checkOutput("post_rst_data", 128'(rd), 128'(32'h13579BDF));

      // Random traffic over a few words with random ack delays.
      e0 = err_pulses;
      for (int i = 0; i < 40; i++) begin
         ack_after_w = int'($urandom_range(5, 0));
         ack_after_r = int'($urandom_range(5, 0));
         a  = 32'h100 + 32'(4 * $urandom_range(7, 0));
         be = 4'($urandom_range(15, 1));
         d  = $urandom;
         if ($urandom_range(1, 0) == 1) begin
            coreWrite(a, be, d, stalls);
         end else begin
            coreRead(a, 4'hF, rd, stalls, err);
            checkOutput("rand_read_data", 128'(rd), 128'(model_word(a)));
            checkOutput("rand_read_err", 128'(err), 128'(0));
         end
      end
      repeat (30) @(posedge iCLK);
      #1;
      checkOutput("rand_no_errors", 128'(err_pulses - e0), 128'(0));

      // Every transaction the slave saw, in issue order.
      checkOutput("log_size", 128'(act_log.size()), 128'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < act_log.size(); i++) begin
         checkOutput("log_kind_addr", 128'({act_log[i].we, act_log[i].addr}),
                     128'({exp_log[i].we, exp_log[i].addr}));
         if (exp_log[i].we) begin
            checkOutput("log_write_be_data", 128'({act_log[i].be, act_log[i].data}),
                        128'({exp_log[i].be, exp_log[i].data}));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
